// File: rtl/pipeline_ifid_buf_if.sv
// pipeline_ifid_buf_if -- fetch/decode handshake bundle for the IF/ID queue.
// master: fetch + decode side (drives offers, consumes head)
// slave : the queue itself
interface pipeline_ifid_buf_if #(
   parameter int DEPTH = 2
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_inst;
   logic [31:0]   if_pc4;
   logic          if_irq;
   logic          flush;
   logic          id_valid;
   logic          id_ready;
   logic [31:0]   id_inst;
   logic [31:0]   id_pc4;
   logic          id_irq;
   logic [CW-1:0] count;

   modport master (
      output if_valid, if_inst, if_pc4, if_irq, flush, id_ready,
      input  if_ready, id_valid, id_inst, id_pc4, id_irq, count
   );

   modport slave (
      input  if_valid, if_inst, if_pc4, if_irq, flush, id_ready,
      output if_ready, id_valid, id_inst, id_pc4, id_irq, count
   );
endinterface

// File: rtl/pipeline_ifid_buf.sv
// pipeline_ifid_buf -- circular instruction queue between fetch and decode.
// Optional feature macro: IFID_BYPASS_EN (empty-queue fetch->decode bypass).
// Without the macro there is no combinational path from if_* to id_*.
module pipeline_ifid_buf #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   pipeline_ifid_buf_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 65;   // {inst[31:0], pc4[31:0], irq}

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          not_full_s;
   logic          not_empty_s;
   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;
   logic [EW-1:0] wr_data_s;
`ifdef IFID_BYPASS_EN
   logic          bypass_s;
`endif

   // Occupancy flags and push/pop decisions; if_ready only looks at registered count.
   always_comb begin
      not_full_s  = (count_q < CW'(DEPTH));
      not_empty_s = (count_q != CW'(0));
      wr_data_s   = {bus.if_inst, bus.if_pc4, bus.if_irq};
      pop_s       = not_empty_s && bus.id_ready && !bus.flush;
`ifdef IFID_BYPASS_EN
      bypass_s    = !not_empty_s && bus.if_valid && !bus.flush;
      // A bypassed word taken by decode this cycle never needs a slot.
      push_s      = bus.if_valid && not_full_s && !bus.flush && !(bypass_s && bus.id_ready);
`else
      push_s      = bus.if_valid && not_full_s && !bus.flush;
`endif
   end

   // Next pointer and occupancy state; flush returns everything to the origin.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = PW'(0);
         rd_ptr_d = PW'(0);
         count_d  = CW'(0);
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         count_q  <= CW'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care once occupancy is cleared.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_data_s;
      end
   end

   // Decode-side view: head entry, bypassed fetch word, or the NOP bubble.
   always_comb begin
      head_s       = mem_q[rd_ptr_q];
      bus.id_valid = 1'b0;
      bus.id_inst  = NOP_INST;
      bus.id_pc4   = 32'h0000_0000;
      bus.id_irq   = 1'b0;
      if (bus.flush) begin
         bus.id_valid = 1'b0;
         bus.id_inst  = NOP_INST;
         bus.id_pc4   = 32'h0000_0000;
         bus.id_irq   = 1'b0;
      end else if (not_empty_s) begin
         bus.id_valid = 1'b1;
         bus.id_inst  = head_s[64:33];
         bus.id_pc4   = head_s[32:1];
         bus.id_irq   = head_s[0];
`ifdef IFID_BYPASS_EN
      end else if (bypass_s) begin
         bus.id_valid = 1'b1;
         bus.id_inst  = bus.if_inst;
         bus.id_pc4   = bus.if_pc4;
         bus.id_irq   = bus.if_irq;
`endif
      end else begin
         bus.id_valid = 1'b0;
         bus.id_inst  = NOP_INST;
         bus.id_pc4   = 32'h0000_0000;
         bus.id_irq   = 1'b0;
      end
   end

   // Fetch-side handshake and occupancy come straight from registered state.
   always_comb begin
      bus.if_ready = not_full_s;
      bus.count    = count_q;
   end
endmodule

// File: tb/tb_pipeline_ifid_buf.sv
// tb_pipeline_ifid_buf -- directed stimulus with a scoreboard queue; a separate
// negedge monitor pops and compares every decode handshake.
module tb_pipeline_ifid_buf;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IFID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   mcount;
   logic [64:0] sb [$];

   pipeline_ifid_buf_if #(.DEPTH(DEPTH)) bus ();

   pipeline_ifid_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted decode handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
         logic [64:0] e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: actual=%0h required=none (t=%0t)", bus.id_inst, $time);
         end else begin
            e = sb.pop_front();
            if ({bus.id_inst, bus.id_pc4, bus.id_irq} !== e) begin
               errors++;
               $display("FAIL sb_entry: actual=%0h/%0h/%0b required=%0h/%0h/%0b (t=%0t)",
                        bus.id_inst, bus.id_pc4, bus.id_irq, e[64:33], e[32:1], e[0], $time);
            end
         end
      end
   end

   // One clock cycle of stimulus plus the expected decode view for that cycle.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                        input logic irq, input logic rdy, input logic fl);
      logic exp_ready, byp, acc, exp_valid;
      logic [64:0] h;
      @(posedge clk);
      #1;
      bus.if_valid = v;
      bus.if_inst  = inst;
      bus.if_pc4   = pc4;
      bus.if_irq   = irq;
      bus.id_ready = rdy;
      bus.flush    = fl;
      #1;
      exp_ready = (mcount < DEPTH);
      byp       = BYP && (mcount == 0) && v && !fl;
      acc       = v && exp_ready && !fl;
      chk("if_ready", 32'(bus.if_ready), 32'(exp_ready));
      chk("count", 32'(bus.count), 32'(mcount));
      if (fl) sb.delete();
      if (acc) sb.push_back({inst, pc4, irq});
      exp_valid = !fl && ((mcount > 0) || byp);
      chk("id_valid", 32'(bus.id_valid), 32'(exp_valid));
      if (exp_valid) begin
         h = sb[0];
         chk("id_inst", bus.id_inst, h[64:33]);
         chk("id_pc4", bus.id_pc4, h[32:1]);
         chk("id_irq", 32'(bus.id_irq), 32'(h[0]));
      end else begin
         chk("id_inst_nop", bus.id_inst, NOP);
         chk("id_pc4_zero", bus.id_pc4, 32'h0000_0000);
         chk("id_irq_zero", 32'(bus.id_irq), 32'h0000_0000);
      end
      if (fl) begin
         mcount = 0;
      end else begin
         mcount = mcount + ((acc && !(byp && rdy)) ? 1 : 0) - (((mcount > 0) && rdy) ? 1 : 0);
      end
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mcount = 0;
      reset  = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_inst  = 32'h0000_0000;
      bus.if_pc4   = 32'h0000_0000;
      bus.if_irq   = 1'b0;
      bus.id_ready = 1'b0;
      bus.flush    = 1'b0;
      #3;
      chk("rst_count", 32'(bus.count), 32'h0000_0000);
      chk("rst_id_valid", 32'(bus.id_valid), 32'h0000_0000);
      chk("rst_id_inst", bus.id_inst, NOP);
      chk("rst_if_ready", 32'(bus.if_ready), 32'h0000_0001);
      #9;
      reset = 1'b0;

      // Single push with decode stalled, then drain.
      cycle(1'b1, 32'h2002_0005, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);

      // Empty queue, fetch and decode both ready (bypass or one-cycle latency).
      cycle(1'b1, 32'h0800_0010, 32'h8000_0014, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Three back-to-back offers into a depth-2 queue; third waits for a pop.
      cycle(1'b1, 32'h0000_0111, 32'h0000_1004, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0222, 32'h0000_1008, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0333, 32'h0000_100C, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0333, 32'h0000_100C, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0333, 32'h0000_100C, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Flush with a full queue and a same-cycle offer.
      cycle(1'b1, 32'h0000_0AAA, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0BBB, 32'h0000_2008, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_200C, 1'b1, 1'b1, 1'b1);
      idle(1'b0);
      idle(1'b1);

      // Steady stream with one entry in flight; pointers wrap several times.
      cycle(1'b1, 32'h1000_0000, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 32'h1000_0000 + 32'(i), 32'h0000_3000 + 32'(4 * i), i[0], 1'b1, 1'b0);
      end
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset while two tagged entries are held.
      cycle(1'b1, 32'h0000_0C01, 32'h0000_4004, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0C02, 32'h0000_4008, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.if_valid = 1'b0;
      bus.id_ready = 1'b0;
      chk("pre_rst_count", 32'(bus.count), 32'h0000_0002);
      chk("pre_rst_irq", 32'(bus.id_irq), 32'h0000_0001);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(bus.id_valid), 32'h0000_0000);
      chk("async_rst_irq", 32'(bus.id_irq), 32'h0000_0000);
      chk("async_rst_count", 32'(bus.count), 32'h0000_0000);
      chk("async_rst_ready", 32'(bus.if_ready), 32'h0000_0001);
      sb.delete();
      mcount = 0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      idle(1'b1);
      cycle(1'b1, 32'h0000_0D01, 32'h0000_5004, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      chk("sb_drained", 32'(sb.size()), 32'h0000_0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
